// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 16;
  localparam int FETCH_INSTR_W = 16;
  localparam int FETCH_PC_STEP = 2;

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue2.sv
// Two-entry FIFO holding fetched {instr, pc} pairs ahead of decode.
// Flush has priority over push and pop in the same cycle.
module fetch_queue2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  assign do_pop     = pop && (count != 2'd0);
  assign head_valid = (count != 2'd0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The fetch credit scheme guarantees a free slot whenever a response lands.
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      assert (!(push && (count == 2'd2) && !pop));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight, queues results for decode.
// Build macro IF_PERF_CNT_EN adds the perf_fetch_cnt / perf_bubble_cnt outputs.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = FETCH_PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_bubble_cnt
`endif
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [1:0]        q_count;
  logic              q_valid;
  fetch_entry_t      q_in;
  fetch_entry_t      q_head;

  // Credit: a new request is only issued while the queue can absorb its response.
  assign imem_req_valid = rst && (state == S_ISSUE) && (q_count <= 2'd1);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop            = q_valid && id_ready && !redirect_valid;

  assign q_in.instr = imem_rsp_data;
  assign q_in.pc    = req_pc;

  assign id_valid   = q_valid;
  assign id_instr   = q_valid ? q_head.instr : '0;
  assign id_pc      = q_valid ? q_head.pc : '0;
  assign id_pc_plus = q_valid ? q_head.pc + ADDR_W'(PC_STEP) : '0;

  fetch_queue2 u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (q_in),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (q_count),
    .head_valid (q_valid),
    .head       (q_head)
  );

  // A redirect kills whatever request is still in flight; its response lands in S_DROP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_ISSUE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
      case (state)
        S_ISSUE:        state <= req_fire ? S_DROP : S_ISSUE;
        S_WAIT, S_DROP: state <= imem_rsp_valid ? S_ISSUE : S_DROP;
        default:        state <= S_ISSUE;
      endcase
    end else begin
      case (state)
        S_ISSUE: begin
          if (req_fire) begin
            req_pc <= pc;
            pc     <= pc + ADDR_W'(PC_STEP);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) state <= S_ISSUE;
        end
        S_DROP: begin
          if (imem_rsp_valid) state <= S_ISSUE;
        end
        default: state <= S_ISSUE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (pop && (perf_fetch_cnt != 16'hFFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      end
      if (id_ready && !q_valid && (perf_bubble_cnt != 16'hFFFF)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random imem/decode/redirect traffic
// compared every cycle against a queue-based model of the fetch stream.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus     (id_pc_plus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // stimulus knobs
  int          ready_pct = 100;
  int          idr_pct   = 100;
  int          lat_min   = 0;
  int          lat_max   = 0;
  int          redir_pct = 0;
  bit          rd_now    = 0;
  bit          rd_on_rsp = 0;
  logic [15:0] rd_target = '0;
  bit          mem_keep  = 0;

  // instruction memory environment
  bit          mem_busy = 0;
  logic [15:0] mem_addr = '0;
  int          mem_cnt  = 0;
  logic [15:0] acc_q[$];
  int          acc_cyc[$];
  logic [15:0] del_pc_q[$];
  logic [15:0] del_plus_q[$];

  // reference model of the fetch stream
  logic [15:0] m_pc = '0;
  logic [15:0] m_req_pc = '0;
  bit          m_out = 0;
  bit          m_killed = 0;
  logic [15:0] mq[$];
  int          m_fetch = 0;
  int          m_bubble = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_busy       = 0;
      end else begin
        mem_cnt--;
      end
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    id_ready       = ($urandom_range(99) < idr_pct);
    if (rd_now) begin
      redirect_valid = 1'b1;
      redirect_pc    = rd_target;
      rd_now         = 0;
    end else if (rd_on_rsp && imem_rsp_valid) begin
      redirect_valid = 1'b1;
      redirect_pc    = rd_target;
      rd_on_rsp      = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      redirect_valid = 1'b1;
      if ($urandom_range(3) == 0) redirect_pc = 16'hFFFC + 16'($urandom_range(3));
      else                        redirect_pc = 16'($urandom());
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_busy = 1;
      mem_addr = imem_req_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
      acc_q.push_back(imem_req_addr);
      acc_cyc.push_back(cycle);
    end
    if (id_valid && id_ready && !redirect_valid) begin
      del_pc_q.push_back(id_pc);
      del_plus_q.push_back(id_pc_plus);
    end
  endtask

  task automatic checkOutput();
    bit          exp_rv;
    logic [15:0] exp_plus;
    exp_rv = !m_out && (mq.size() <= 1);
    checkValue("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) checkValue("req_addr", imem_req_addr, m_pc);
    checkValue("id_valid", id_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      exp_plus = mq[0] + 16'd2;
      checkValue("id_pc", id_pc, mq[0]);
      checkValue("id_instr", id_instr, mem_word(mq[0]));
      checkValue("id_pc_plus", id_pc_plus, exp_plus);
    end
`ifdef IF_PERF_CNT_EN
    checkValue("perf_fetch", perf_fetch_cnt, m_fetch);
    checkValue("perf_bubble", perf_bubble_cnt, m_bubble);
`endif
  endtask

  task automatic modelStep();
    bit hs;
    bit pop;
    hs  = !m_out && (mq.size() <= 1) && imem_req_ready;
    pop = (mq.size() > 0) && id_ready && !redirect_valid;
    if (pop && m_fetch < 65535) m_fetch++;
    if (id_ready && mq.size() == 0 && m_bubble < 65535) m_bubble++;
    if (redirect_valid) begin
      mq.delete();
      if (m_out) begin
        if (imem_rsp_valid) begin
          m_out = 0;
          m_killed = 0;
        end else begin
          m_killed = 1;
        end
      end else if (hs) begin
        m_out = 1;
        m_killed = 1;
      end
      m_pc = redirect_pc & 16'hFFFE;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_out && imem_rsp_valid) begin
        if (!m_killed) mq.push_back(m_req_pc);
        m_out = 0;
        m_killed = 0;
      end else if (hs) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 16'd2;
        m_out    = 1;
        m_killed = 0;
      end
    end
  endtask

  task automatic stepBody();
    cycle++;
    applyStimulus();
    #1;
    checkOutput();
    modelStep();
  endtask

  task automatic stepCycle();
    @(negedge clk);
    stepBody();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic resetDut(input int n);
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    if (!mem_keep) mem_busy = 0;
    m_pc = '0; m_out = 0; m_killed = 0; mq.delete(); m_fetch = 0; m_bubble = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      checkValue("rst_req_valid", imem_req_valid, 0);
      checkValue("rst_id_valid", id_valid, 0);
      checkValue("rst_id_instr", id_instr, 0);
      checkValue("rst_id_pc", id_pc, 0);
      checkValue("rst_id_pc_plus", id_pc_plus, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    stepBody();
  endtask

  task automatic waitAccept(input int lat, input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      stepCycle();
      if (mem_busy && mem_cnt == lat) seen = 1;
    end
    if (!seen) checkValue({name, "_timeout"}, 0, 1);
  endtask

  task automatic redirectOnResponse(input logic [15:0] target, input string name);
    rd_target = target;
    rd_on_rsp = 1;
    for (int i = 0; i < 40 && rd_on_rsp; i++) stepCycle();
    if (rd_on_rsp) begin
      checkValue({name, "_timeout"}, 0, 1);
      rd_on_rsp = 0;
    end
    acc_q.delete();
    del_pc_q.delete();
    del_plus_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;

    // 1: streaming at one-cycle latency
    resetDut(2);
    runCycles(7);
    checkValue("t1_acc_n", acc_q.size(), 4);
    if (acc_q.size() >= 4) begin
      checkValue("t1_acc0", acc_q[0], 16'h0000);
      checkValue("t1_acc1", acc_q[1], 16'h0002);
      checkValue("t1_acc2", acc_q[2], 16'h0004);
      checkValue("t1_acc_gap", acc_cyc[1] - acc_cyc[0], 2);
    end
    checkValue("t1_del_n", del_pc_q.size(), 3);
    if (del_pc_q.size() >= 3) begin
      checkValue("t1_del0", del_pc_q[0], 16'h0000);
      checkValue("t1_del2", del_pc_q[2], 16'h0004);
    end

    // 2: decode stall fills the queue, release drains in order
    idr_pct = 0;
    runCycles(10);
    @(posedge clk);
    #1;
    checkValue("t2_req_valid_full", imem_req_valid, 0);
    checkValue("t2_id_valid_full", id_valid, 1);
    del_pc_q.delete();
    idr_pct = 100;
    runCycles(10);
    checkValue("t2_del_n", del_pc_q.size() >= 4, 1);
    for (int i = 0; i + 1 < del_pc_q.size(); i++)
      checkValue("t2_order", del_pc_q[i + 1], del_pc_q[i] + 16'd2);

    // 3: redirect while waiting, stale response arrives later
    lat_min = 2; lat_max = 2;
    waitAccept(2, "t3_accept");
    rd_target = 16'h0041;
    rd_now = 1;
    stepCycle();
    acc_q.delete();
    del_pc_q.delete();
    @(posedge clk);
    #1;
    checkValue("t3_id_valid_after_redirect", id_valid, 0);
    runCycles(12);
    checkValue("t3_acc_n", acc_q.size() >= 1, 1);
    if (acc_q.size() >= 1) checkValue("t3_next_addr", acc_q[0], 16'h0040);
    checkValue("t3_del_n", del_pc_q.size() >= 1, 1);
    if (del_pc_q.size() >= 1) checkValue("t3_first_pc", del_pc_q[0], 16'h0040);

    // 4: redirect coincident with response
    lat_min = 0; lat_max = 0;
    redirectOnResponse(16'h1234, "t4");
    runCycles(8);
    if (acc_q.size() >= 1) checkValue("t4_next_addr", acc_q[0], 16'h1234);
    else checkValue("t4_acc_n", 0, 1);
    if (del_pc_q.size() >= 1) checkValue("t4_first_pc", del_pc_q[0], 16'h1234);
    else checkValue("t4_del_n", 0, 1);

    // 5: PC wrap
    redirectOnResponse(16'hFFFE, "t5");
    runCycles(8);
    if (acc_q.size() >= 2) begin
      checkValue("t5_addr0", acc_q[0], 16'hFFFE);
      checkValue("t5_addr1", acc_q[1], 16'h0000);
    end else checkValue("t5_acc_n", acc_q.size(), 2);
    if (del_pc_q.size() >= 1) begin
      checkValue("t5_pc", del_pc_q[0], 16'hFFFE);
      checkValue("t5_pc_plus", del_plus_q[0], 16'h0000);
    end else checkValue("t5_del_n", 0, 1);

    // reset while a request is outstanding; memory answers late anyway
    lat_min = 3; lat_max = 3;
    mem_keep = 1;
    waitAccept(3, "rst_accept");
    ready_pct = 0;
    resetDut(2);
    runCycles(6);
    mem_keep = 0;
    @(posedge clk);
    #1;
    checkValue("late_rsp_ignored", id_valid, 0);
    ready_pct = 100;
    lat_min = 0; lat_max = 0;
    runCycles(6);

    // random traffic
    ready_pct = 70; idr_pct = 70; lat_min = 0; lat_max = 3; redir_pct = 6;
    runCycles(3000);
    redir_pct = 0;

`ifdef IF_PERF_CNT_EN
    ready_pct = 0; idr_pct = 100;
    resetDut(1);
    runCycles(2);
    @(posedge clk);
    #1;
    checkValue("perf_bubble3", perf_bubble_cnt, 16'd3);
    checkValue("perf_fetch0", perf_fetch_cnt, 16'd0);
    ready_pct = 100; lat_min = 0; lat_max = 0;
    del_pc_q.delete();
    for (int i = 0; i < 100 && del_pc_q.size() < 5; i++) stepCycle();
    @(posedge clk);
    #1;
    checkValue("perf_fetch5", perf_fetch_cnt, 16'd5);
    ready_pct = 0;
    runCycles(65540);
    @(posedge clk);
    #1;
    checkValue("perf_bubble_sat", perf_bubble_cnt, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
